// File: rtl/disc_draw_ctrl_if.sv
// Drop-request handshake plus datapath/VGA control bundle for disc_draw_ctrl.
// Cursor preview signals exist only when DISC_DRAW_PREVIEW_EN is defined.
interface disc_draw_ctrl_if;
  logic       drop_valid;
  logic [2:0] drop_col;
  logic       drop_player;
  logic       drop_ready;
  logic       drop_done;
  logic       drop_reject;
  logic       board_full;
  logic [3:0] pixel_count;
  logic [2:0] decoded_height;
  logic [2:0] location;
  logic       go;
  logic       player;
  logic       plot;
`ifdef DISC_DRAW_PREVIEW_EN
  logic [2:0] cursor_col;
  logic       cursor_player;

  modport master (
    output drop_valid, drop_col, drop_player, cursor_col, cursor_player,
    input  drop_ready, drop_done, drop_reject, board_full,
    input  pixel_count, decoded_height, location, go, player, plot
  );
  modport slave (
    input  drop_valid, drop_col, drop_player, cursor_col, cursor_player,
    output drop_ready, drop_done, drop_reject, board_full,
    output pixel_count, decoded_height, location, go, player, plot
  );
`else
  modport master (
    output drop_valid, drop_col, drop_player,
    input  drop_ready, drop_done, drop_reject, board_full,
    input  pixel_count, decoded_height, location, go, player, plot
  );
  modport slave (
    input  drop_valid, drop_col, drop_player,
    output drop_ready, drop_done, drop_reject, board_full,
    output pixel_count, decoded_height, location, go, player, plot
  );
`endif
endinterface

// File: rtl/disc_draw_ctrl.sv
// Disc drop controller: column fill tracking, landing-row calculation and 4x4 disc plot sequencing.
// Optional cursor preview drawing is enabled by defining DISC_DRAW_PREVIEW_EN.
module disc_draw_ctrl #(
  parameter int NUM_COLS    = 7,
  parameter int NUM_ROWS    = 6,
  parameter int DISC_PIXELS = 16
) (
  input logic             clk,
  input logic             resetn,
  disc_draw_ctrl_if.slave bus
);
  localparam int              FW         = $clog2(NUM_ROWS + 1);
  localparam logic [3:0]      LAST_PIXEL = 4'(DISC_PIXELS - 1);
  localparam logic [FW-1:0]   FULL_LEVEL = FW'(NUM_ROWS);

`ifdef DISC_DRAW_PREVIEW_EN
  typedef enum logic [2:0] {IDLE, CHECK, DRAW, UPDATE, PREVIEW} state_t;
`else
  typedef enum logic [1:0] {IDLE, CHECK, DRAW, UPDATE} state_t;
`endif

  state_t        state_q, state_d;
  logic [FW-1:0] fill_q [NUM_COLS];
  logic [FW-1:0] fill_d [NUM_COLS];
  logic [3:0]    pixel_count_q, pixel_count_d;
  logic [2:0]    decoded_height_q, decoded_height_d;
  logic [2:0]    location_q, location_d;
  logic          go_q, go_d;
  logic          player_q, player_d;
  logic          plot_q, plot_d;
  logic [FW-1:0] cur_fill;
  logic          col_legal;
  logic          board_full_c;
  logic          drop_done_c;
  logic          drop_reject_c;
`ifdef DISC_DRAW_PREVIEW_EN
  logic [2:0]    cursor_col_q, cursor_col_d;
  logic          cursor_player_q, cursor_player_d;
`endif

  // Fill level of the latched column; an out-of-range column matches no entry.
  always_comb begin
    cur_fill     = '0;
    col_legal    = 1'b0;
    board_full_c = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (location_q == 3'(c)) begin
        cur_fill  = fill_q[c];
        col_legal = 1'b1;
      end
      if (fill_q[c] != FULL_LEVEL) board_full_c = 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    fill_d           = fill_q;
    pixel_count_d    = pixel_count_q;
    decoded_height_d = decoded_height_q;
    location_d       = location_q;
    go_d             = go_q;
    player_d         = player_q;
    plot_d           = 1'b0;
    drop_done_c      = 1'b0;
    drop_reject_c    = 1'b0;
`ifdef DISC_DRAW_PREVIEW_EN
    cursor_col_d     = cursor_col_q;
    cursor_player_d  = cursor_player_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.drop_valid) begin
          location_d = bus.drop_col;
          player_d   = bus.drop_player;
          state_d    = CHECK;
        end
`ifdef DISC_DRAW_PREVIEW_EN
        // A pending cursor change stays pending until IDLE has no drop to accept.
        else if (bus.cursor_col != cursor_col_q || bus.cursor_player != cursor_player_q) begin
          cursor_col_d    = bus.cursor_col;
          cursor_player_d = bus.cursor_player;
          if (32'(bus.cursor_col) < NUM_COLS) begin
            location_d    = bus.cursor_col;
            player_d      = bus.cursor_player;
            go_d          = 1'b0;
            pixel_count_d = '0;
            state_d       = PREVIEW;
          end
        end
`endif
      end
      CHECK: begin
        if (!col_legal || cur_fill == FULL_LEVEL) begin
          drop_reject_c = 1'b1;
          state_d       = IDLE;
        end else begin
          decoded_height_d = 3'(NUM_ROWS - 1 - int'(cur_fill));
          go_d             = 1'b1;
          pixel_count_d    = '0;
          state_d          = DRAW;
        end
      end
      // plot trails pixel_count by one cycle to match the datapath's x/y register.
      DRAW: begin
        plot_d        = 1'b1;
        pixel_count_d = pixel_count_q + 4'd1;
        if (pixel_count_q == LAST_PIXEL) begin
          pixel_count_d = '0;
          state_d       = UPDATE;
        end
      end
      UPDATE: begin
        drop_done_c = 1'b1;
        state_d     = IDLE;
        for (int c = 0; c < NUM_COLS; c++) begin
          if (location_q == 3'(c) && fill_q[c] != FULL_LEVEL) fill_d[c] = fill_q[c] + FW'(1);
        end
      end
`ifdef DISC_DRAW_PREVIEW_EN
      PREVIEW: begin
        plot_d        = 1'b1;
        pixel_count_d = pixel_count_q + 4'd1;
        if (pixel_count_q == LAST_PIXEL) begin
          pixel_count_d = '0;
          state_d       = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      fill_q           <= '{default: '0};
      pixel_count_q    <= '0;
      decoded_height_q <= '0;
      location_q       <= '0;
      go_q             <= 1'b0;
      player_q         <= 1'b0;
      plot_q           <= 1'b0;
`ifdef DISC_DRAW_PREVIEW_EN
      cursor_col_q     <= '0;
      cursor_player_q  <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      fill_q           <= fill_d;
      pixel_count_q    <= pixel_count_d;
      decoded_height_q <= decoded_height_d;
      location_q       <= location_d;
      go_q             <= go_d;
      player_q         <= player_d;
      plot_q           <= plot_d;
`ifdef DISC_DRAW_PREVIEW_EN
      cursor_col_q     <= cursor_col_d;
      cursor_player_q  <= cursor_player_d;
`endif
    end
  end

  assign bus.drop_ready     = (state_q == IDLE);
  assign bus.drop_done      = drop_done_c;
  assign bus.drop_reject    = drop_reject_c;
  assign bus.board_full     = board_full_c;
  assign bus.pixel_count    = pixel_count_q;
  assign bus.decoded_height = decoded_height_q;
  assign bus.location       = location_q;
  assign bus.go             = go_q;
  assign bus.player         = player_q;
  assign bus.plot           = plot_q;

endmodule
